// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, through a
// single full-subtractor cell. Reports difference, final borrow and signed
// overflow with a one-cycle done pulse.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   r_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               brw;
  logic               a_msb;
  logic               b_msb;
  logic               cell_d;
  logic               cell_bout;
  logic               last_bit;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The result register fills from the MSB side, so after WIDTH shifts bit 0 sits at bit 0.
  assign r_nxt    = {cell_d, r_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Next-state and status outputs derived from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All sequential state: FSM, operand/result shifters, borrow, counter and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            r_sr  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nxt;
          brw  <= cell_bout;
          cnt  <= cnt + CNT_W'(1);
          // Results are published only once, on the final bit, so they hold between operations.
          if (last_bit) begin
            d    <= r_nxt;
            bout <= cell_bout;
            ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases, random operands, continuous
// start, mid-operation reset, and an exhaustive 4-bit sweep against an
// arithmetic reference model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] d8;
  logic       bout8;
  logic       ovf8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] d4;
  logic       bout4;
  logic       ovf4;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned av_q [0:47];
  int unsigned bv_q [0:47];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .d     (d8),
    .bout  (bout8),
    .ovf   (ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .d     (d4),
    .bout  (bout4),
    .ovf   (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on w-bit operands.
  function automatic void ref_sub(input int w, input int unsigned av, input int unsigned bv,
                                  output int unsigned dv, output bit bo, output bit ov);
    int unsigned m;
    int sa;
    int sb;
    int diff;
    m  = (32'd1 << w) - 1;
    dv = (av - bv) & m;
    bo = (av < bv);
    sa = (av >= (32'd1 << (w - 1))) ? int'(av) - (1 << w) : int'(av);
    sb = (bv >= (32'd1 << (w - 1))) ? int'(bv) - (1 << w) : int'(bv);
    diff = sa - sb;
    ov = (diff > (1 << (w - 1)) - 1) || (diff < -(1 << (w - 1)));
  endfunction

  task automatic op8(input logic [7:0] av, input logic [7:0] bv);
    int cyc;
    int unsigned ed;
    bit eb;
    bit eo;
    ref_sub(8, av, bv, ed, eb, eo);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    check("lat8", cyc, 9);
    check("d8", d8, ed);
    check("bout8", bout8, eb);
    check("ovf8", ovf8, eo);
    @(negedge clk);
    check("pulse8", done8, 0);
    check("hold8", d8, ed);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv);
    int cyc;
    int unsigned ed;
    bit eb;
    bit eo;
    ref_sub(4, av, bv, ed, eb, eo);
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    cyc = 1;
    while (done4 !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("lat4", cyc, 5);
    check("d4", d4, ed);
    check("bout4", bout4, eb);
    check("ovf4", ovf4, eo);
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    int unsigned ed;
    bit eb;
    bit eo;
    bit exp_done;

    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_d", d8, 0);
    check("rst_bout", bout8, 0);
    check("rst_ovf", ovf8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    op8(8'h5A, 8'h3C);
    op8(8'h00, 8'h01);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'hFF);
    op8(8'hFF, 8'hFF);

    // Random operands
    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom));

    // start held high with operands changing every cycle
    for (int n = 0; n < 42; n++) begin
      @(negedge clk);
      if (n > 0) begin
        exp_done = (((n - 1) % 10) == 8);
        check("cont_done", done8, exp_done);
        if (exp_done) begin
          ref_sub(8, av_q[n - 9], bv_q[n - 9], ed, eb, eo);
          check("cont_d", d8, ed);
          check("cont_bout", bout8, eb);
          check("cont_ovf", ovf8, eo);
        end
      end
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
      av_q[n] = a8; bv_q[n] = b8;
    end
    start8 = 1'b0;
    ndone = 0;
    while (busy8 === 1'b1 && ndone < 20) begin
      @(negedge clk);
      ndone++;
    end
    check("cont_idle", busy8, 0);

    // Reset in the middle of an operation
    op8(8'h80, 8'h01);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy8, 0);
    check("mid_done", done8, 0);
    check("mid_d", d8, 0);
    check("mid_bout", bout8, 0);
    check("mid_ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    check("mid_nodone", ndone, 0);
    op8(8'h10, 8'h10);

    // Exhaustive 4-bit sweep
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
